// File: rtl/iiitb_pwm_multi.sv
// Multi-channel PWM generator: one shared edge/centre-aligned period counter,
// per-channel debounced duty buttons, and duty/mode reload only at period boundaries.
module iiitb_pwm_multi #(
    parameter int NCH       = 2,
    parameter int CW        = 8,
    parameter int PERIOD    = 10,
    parameter int STEP      = 1,
    parameter int DUTY_INIT = 5,
    parameter int DEB_DIV   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    increase_duty,
    input  logic [NCH-1:0]    decrease_duty,
    input  logic              center_mode,
    input  logic              pwm_enable,
    output logic [NCH-1:0]    pwm_out,
    output logic [NCH*CW-1:0] duty_level,
    output logic              period_tick
);

    localparam int PW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DEB_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PERIOD - 1);
    localparam logic [CW-1:0] DUTY_RST   = CW'(DUTY_INIT);
    localparam logic [CW:0]   STEP_W     = (CW+1)'(STEP);
    localparam logic [CW:0]   PERIOD_W   = (CW+1)'(PERIOD);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0]  presc_q;
    logic           sample_en;
    logic [NCH-1:0] inc_s1_q, inc_s2_q, dec_s1_q, dec_s2_q;
    logic [NCH-1:0] inc_press, dec_press;

    logic [CW-1:0]  shadow_q [NCH];
    logic [CW-1:0]  shadow_d [NCH];
    logic [CW-1:0]  act_q    [NCH];

    logic [CW-1:0]  cnt_q;
    dir_e           dir_q;
    logic           mode_q;
    logic           boundary;
    logic [NCH-1:0] pwm_q;
    logic           tick_q;

    // Saturating duty step computed one bit wider so it can never wrap.
    function automatic logic [CW-1:0] next_duty(input logic [CW-1:0] duty,
                                                input logic          inc,
                                                input logic          dec);
        logic [CW:0] wide;
        wide = {1'b0, duty};
        if (inc && !dec) begin
            wide = (wide + STEP_W > PERIOD_W) ? PERIOD_W : wide + STEP_W;
        end else if (dec && !inc) begin
            wide = (wide < STEP_W) ? '0 : wide - STEP_W;
        end
        return wide[CW-1:0];
    endfunction

    assign sample_en = (presc_q == PRESC_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            inc_s1_q <= '0;
            inc_s2_q <= '0;
            dec_s1_q <= '0;
            dec_s2_q <= '0;
        end else begin
            presc_q <= sample_en ? '0 : presc_q + PW'(1);
            if (sample_en) begin
                inc_s1_q <= increase_duty;
                inc_s2_q <= inc_s1_q;
                dec_s1_q <= decrease_duty;
                dec_s2_q <= dec_s1_q;
            end
        end
    end

    // One pulse per press: rising edge between two consecutive samples.
    assign inc_press = inc_s1_q & ~inc_s2_q & {NCH{sample_en}};
    assign dec_press = dec_s1_q & ~dec_s2_q & {NCH{sample_en}};

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            shadow_d[i] = next_duty(shadow_q[i], inc_press[i], dec_press[i]);
        end
    end

    assign boundary = pwm_enable &&
                      (mode_q ? (cnt_q == '0 && dir_q == DIR_DOWN) : (cnt_q == CNT_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= 1'b0;
            pwm_q  <= '0;
            tick_q <= 1'b0;
            // NOTE: the duty arrays are architectural state visible on duty_level,
            // so every entry is reset, unlike a plain data memory.
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= DUTY_RST;
                act_q[i]    <= DUTY_RST;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                pwm_q[i]    <= pwm_enable && (cnt_q < act_q[i]);
            end
            tick_q <= boundary;

            // Disabled: active settings follow the shadows so enabling starts clean.
            if (!pwm_enable || boundary) begin
                cnt_q  <= '0;
                dir_q  <= DIR_UP;
                mode_q <= center_mode;
                for (int i = 0; i < NCH; i++) begin
                    act_q[i] <= shadow_q[i];
                end
            end else if (!mode_q) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == CNT_LAST) begin
                    dir_q <= DIR_DOWN;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            duty_level[i*CW +: CW] = shadow_q[i];
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_iiitb_pwm_multi.sv
// Self-checking bench for iiitb_pwm_multi: a period-position model is compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_iiitb_pwm_multi;

    localparam int NCH       = 2;
    localparam int CW        = 8;
    localparam int PERIOD    = 10;
    localparam int STEP      = 1;
    localparam int DUTY_INIT = 5;
    localparam int DEB_DIV   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    increase_duty;
    logic [NCH-1:0]    decrease_duty;
    logic              center_mode;
    logic              pwm_enable;
    logic [NCH-1:0]    pwm_out;
    logic [NCH*CW-1:0] duty_level;
    logic              period_tick;

    always #5 clk = ~clk;

    iiitb_pwm_multi #(
        .NCH(NCH), .CW(CW), .PERIOD(PERIOD), .STEP(STEP),
        .DUTY_INIT(DUTY_INIT), .DEB_DIV(DEB_DIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .increase_duty(increase_duty),
        .decrease_duty(decrease_duty),
        .center_mode(center_mode),
        .pwm_enable(pwm_enable),
        .pwm_out(pwm_out),
        .duty_level(duty_level),
        .period_tick(period_tick)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: position within the current period (0..len-1) rather than a counter/direction pair.
    bit             model_valid = 1'b0;
    int             m_presc;
    int             m_phase;
    bit             m_mode;
    int             m_shadow [NCH];
    int             m_act    [NCH];
    bit             m_inc_new [NCH], m_inc_old [NCH];
    bit             m_dec_new [NCH], m_dec_old [NCH];
    logic [NCH-1:0] m_pwm;
    bit             m_tick;

    always @(posedge clk) begin
        bit sample;
        bit bnd;
        bit inc;
        bit dec;
        int len;
        int level;
        if (reset) begin
            model_valid = 1'b1;
            m_presc = 0;
            m_phase = 0;
            m_mode  = 1'b0;
            m_pwm   = '0;
            m_tick  = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_shadow[c]  = DUTY_INIT;
                m_act[c]     = DUTY_INIT;
                m_inc_new[c] = 1'b0;
                m_inc_old[c] = 1'b0;
                m_dec_new[c] = 1'b0;
                m_dec_old[c] = 1'b0;
            end
        end else if (model_valid) begin
            sample = (m_presc == DEB_DIV - 1);
            len    = m_mode ? 2 * PERIOD : PERIOD;
            level  = (m_mode && m_phase >= PERIOD) ? (2 * PERIOD - 1 - m_phase) : m_phase;
            bnd    = pwm_enable && (m_phase == len - 1);
            for (int c = 0; c < NCH; c++) begin
                m_pwm[c] = pwm_enable && (level < m_act[c]);
            end
            m_tick = bnd;
            if (!pwm_enable || bnd) begin
                m_phase = 0;
                m_mode  = center_mode;
                for (int c = 0; c < NCH; c++) m_act[c] = m_shadow[c];
            end else begin
                m_phase++;
            end
            for (int c = 0; c < NCH; c++) begin
                inc = sample && m_inc_new[c] && !m_inc_old[c];
                dec = sample && m_dec_new[c] && !m_dec_old[c];
                if (inc && !dec) begin
                    m_shadow[c] = (m_shadow[c] + STEP > PERIOD) ? PERIOD : m_shadow[c] + STEP;
                end else if (dec && !inc) begin
                    m_shadow[c] = (m_shadow[c] < STEP) ? 0 : m_shadow[c] - STEP;
                end
                if (sample) begin
                    m_inc_old[c] = m_inc_new[c];
                    m_inc_new[c] = increase_duty[c];
                    m_dec_old[c] = m_dec_new[c];
                    m_dec_new[c] = decrease_duty[c];
                end
            end
            m_presc = (m_presc + 1) % DEB_DIV;
        end
    end

    always @(negedge clk) begin
        logic [NCH*CW-1:0] exp_dl;
        if (model_valid) begin
            for (int c = 0; c < NCH; c++) exp_dl[c*CW +: CW] = CW'(m_shadow[c]);
            check("model_pwm_out", 64'(pwm_out), 64'(m_pwm));
            check("model_duty_level", 64'(duty_level), 64'(exp_dl));
            check("model_period_tick", 64'(period_tick), 64'(m_tick));
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit up, input int ch);
        if (up) increase_duty[ch] = 1'b1;
        else    decrease_duty[ch] = 1'b1;
        wait_cycles(3 * DEB_DIV);
        if (up) increase_duty[ch] = 1'b0;
        else    decrease_duty[ch] = 1'b0;
        wait_cycles(3 * DEB_DIV);
    endtask

    task automatic measure(input int n, output int hi0, output int hi1, output int ticks);
        hi0 = 0;
        hi1 = 0;
        ticks = 0;
        repeat (n) begin
            @(negedge clk);
            hi0   += int'(pwm_out[0]);
            hi1   += int'(pwm_out[1]);
            ticks += int'(period_tick);
        end
    endtask

    initial begin
        int hi0, hi1, ticks;
        reset = 1'b1;
        increase_duty = '0;
        decrease_duty = '0;
        center_mode = 1'b0;
        pwm_enable = 1'b0;
        wait_cycles(3);
        check("reset_pwm_out", 64'(pwm_out), 64'd0);
        check("reset_tick", 64'(period_tick), 64'd0);
        check("reset_duty_level", 64'(duty_level), 64'h0505);

        // Edge mode at initial duty: 5 high / 5 low, tick every 10.
        reset = 1'b0;
        pwm_enable = 1'b1;
        wait_cycles(5);
        measure(40, hi0, hi1, ticks);
        check("edge_init_hi0", 64'(hi0), 64'd20);
        check("edge_init_hi1", 64'(hi1), 64'd20);
        check("edge_init_ticks", 64'(ticks), 64'd4);

        // Long hold counts as one press.
        increase_duty[0] = 1'b1;
        wait_cycles(100);
        increase_duty[0] = 1'b0;
        wait_cycles(12);
        check("hold_once_duty", 64'(duty_level), 64'h0506);
        measure(40, hi0, hi1, ticks);
        check("duty6_hi0", 64'(hi0), 64'd24);
        check("duty6_hi1", 64'(hi1), 64'd20);

        // Saturate at PERIOD, then floor at 0.
        repeat (6) press(1'b1, 0);
        check("sat_top_duty", 64'(duty_level), 64'h050A);
        measure(20, hi0, hi1, ticks);
        check("sat_top_hi0", 64'(hi0), 64'd20);
        repeat (12) press(1'b0, 0);
        check("sat_bot_duty", 64'(duty_level), 64'h0500);
        measure(20, hi0, hi1, ticks);
        check("sat_bot_hi0", 64'(hi0), 64'd0);

        // Simultaneous inc and dec cancel.
        increase_duty[1] = 1'b1;
        decrease_duty[1] = 1'b1;
        wait_cycles(12);
        increase_duty[1] = 1'b0;
        decrease_duty[1] = 1'b0;
        wait_cycles(12);
        check("both_btn_duty", 64'(duty_level), 64'h0500);

        // Centre mode requested mid-period.
        wait_cycles(3);
        center_mode = 1'b1;
        wait_cycles(40);
        measure(40, hi0, hi1, ticks);
        check("centre_hi1", 64'(hi1), 64'd20);
        check("centre_hi0", 64'(hi0), 64'd0);
        check("centre_ticks", 64'(ticks), 64'd2);

        // Reset mid-period, then disabled output with live buttons.
        center_mode = 1'b0;
        wait_cycles(30);
        repeat (8) press(1'b1, 0);
        check("duty8_level", 64'(duty_level), 64'h0508);
        wait_cycles($urandom_range(1, 9));
        reset = 1'b1;
        wait_cycles(1);
        check("midreset_pwm", 64'(pwm_out), 64'd0);
        check("midreset_duty", 64'(duty_level), 64'h0505);
        pwm_enable = 1'b0;
        reset = 1'b0;
        press(1'b1, 0);
        check("disabled_duty", 64'(duty_level), 64'h0506);
        measure(20, hi0, hi1, ticks);
        check("disabled_hi", 64'(hi0 + hi1), 64'd0);
        check("disabled_ticks", 64'(ticks), 64'd0);
        pwm_enable = 1'b1;

        // Randomized traffic; the per-cycle model does the checking.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 11) == 0) increase_duty[c] = ~increase_duty[c];
                if ($urandom_range(0, 11) == 0) decrease_duty[c] = ~decrease_duty[c];
            end
            if ($urandom_range(0, 199) == 0) center_mode = ~center_mode;
            if ($urandom_range(0, 299) == 0) pwm_enable  = ~pwm_enable;
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0;
        wait_cycles(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
